mesh_feeder: RTL and testbench
==============================

MESH_FEEDER -- requirements
Module: mesh_feeder

Interface
REQ-001 The block SHALL have parameter ROWS, default 4, meaning number of PE rows (MESHROWS*TILEROWS), minimum 1.
REQ-002 The block SHALL have parameter COLS, default 4, meaning number of PE columns (MESHCOLUMNS*TILECOLUMNS), minimum 1.
REQ-003 The block SHALL have parameter BITWIDTH, default 8, meaning signed element width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, on the ports listed in REQ-005 and REQ-006.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  block accepts beat this cycle.
REQ-009 in_last  input  1  beat is the final one of a batch.
REQ-010 in_a  input  ROWS*BITWIDTH  one A element per row; lane i at bits [i*BITWIDTH +: BITWIDTH].
REQ-011 in_b  input  COLS*BITWIDTH  one B element per column, same lane packing.
REQ-012 in_d  input  COLS*BITWIDTH  one D (preload/bias) element per column.
REQ-013 in_dataflow  input  1  dataflow select for the beat.
REQ-014 in_propagate  input  1  propagate flag for the beat.
REQ-015 out_a  output  ROWS*BITWIDTH  skewed A lanes to mesh west edge.
REQ-016 out_b, out_d  output  COLS*BITWIDTH each  skewed B and D lanes to mesh north edge.
REQ-017 out_dataflow, out_propagate, out_valid  output  COLS each  skewed per-column control to mesh north edge.
REQ-018 busy  output  1  high in STREAM or DRAIN.
REQ-019 done  output  1  one-cycle pulse when a batch has fully left the skew pipeline.

Function
REQ-020 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1; this edge defines cycle T.
REQ-021 FSM states SHALL be IDLE, STREAM, DRAIN.
- IDLE -> STREAM on an accepted beat with in_last=0.
- IDLE -> DRAIN on an accepted beat with in_last=1.
- STREAM -> DRAIN on an accepted beat with in_last=1.
- DRAIN -> IDLE when the drain counter expires.
REQ-022 in_ready SHALL be 1 in IDLE and STREAM and 0 in DRAIN; in_ready SHALL NOT depend combinationally on in_valid.
REQ-023 A-lane i of a beat accepted at T SHALL appear on out_a lane i during cycle T+1+i only.
REQ-024 B-lane, D-lane, dataflow, propagate and valid of column j of a beat accepted at T SHALL appear on column j outputs during cycle T+1+j only.
REQ-025 Cycles with no accepted beat (bubbles) SHALL inject zero data, out_valid=0, dataflow=0 and propagate=0 into every skew stage.
- Bubbles SHALL NOT end the batch.
REQ-026 Data SHALL pass unmodified: no arithmetic, sign preserved, no width change.
REQ-027 On entering DRAIN, a counter SHALL load max(ROWS,COLS)-1 and decrement each cycle.
- On the cycle it reaches 0, the FSM SHALL return to IDLE and done SHALL be 1 for exactly that cycle.
- Result: done is high at cycle T_last+max(ROWS,COLS), coinciding with the final lane output.
REQ-028 For ROWS=COLS=1, DRAIN SHALL last one cycle, with done at T_last+1.
REQ-029 busy SHALL be 1 exactly when the state is not IDLE.
REQ-030 Output lanes SHALL be driven directly from registers.
- The skew for lane k SHALL be k+1 register stages.
- No output lane SHALL be driven combinationally from an input.
REQ-031 The output side SHALL have no backpressure; skew stages SHALL shift every cycle regardless of state.

Reset
REQ-032 While reset=1 at a rising edge, all skew registers SHALL be cleared to 0 and the FSM SHALL go to IDLE.
- Consequence: out_a, out_b, out_d, out_dataflow, out_propagate, out_valid, busy and done read 0 in the following cycle.
- in_ready reads 1 in the following cycle.
REQ-033 A reset during STREAM or DRAIN SHALL discard all in-flight beats with no done pulse; a beat presented in the reset cycle SHALL NOT be accepted.

Verification (ROWS=COLS=4, BITWIDTH=8)
REQ-034 Single beat, in_last=1, a=(1,2,3,4), b=(5,6,7,8) at T -> out_a lane i = i+1 only at T+1+i; out_b lane j = j+5 and out_valid[j]=1 only at T+1+j; done=1 at T+4; in_ready=0 T+1..T+4.
REQ-035 Three back-to-back beats, a lane0 = 10, 20, 30, third with in_last -> out_a lane0 shows 10, 20, 30 at T+1..T+3; out_valid[3] high T+4..T+6; done at T+6.
REQ-036 Beat, bubble, beat(last) -> each column shows pattern valid,0,valid with zero data in the bubble slot; done at T+6.
REQ-037 Negative values: a lane3 = -128, d lane2 = -1 -> emitted bit-exact (0x80, 0xFF) at T+4 and T+3 respectively.
REQ-038 Reset asserted at T+2 of a 3-beat batch -> all outputs 0 from T+3, no done pulse, in_ready=1, busy=0.
REQ-039 in_valid held 1 during DRAIN -> no beat accepted until done; the next beat is accepted in the first IDLE cycle.

Source files
------------

// File: rtl/mesh_feeder_if.sv
// Handshake and lane bundle between an upstream beat source, the mesh feeder
// and the systolic mesh edges.
interface mesh_feeder_if #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int BITWIDTH = 8
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  logic [ROWS*BITWIDTH-1:0] in_a;
  logic [COLS*BITWIDTH-1:0] in_b;
  logic [COLS*BITWIDTH-1:0] in_d;
  logic                     in_dataflow;
  logic                     in_propagate;
  logic [ROWS*BITWIDTH-1:0] out_a;
  logic [COLS*BITWIDTH-1:0] out_b;
  logic [COLS*BITWIDTH-1:0] out_d;
  logic [COLS-1:0]          out_dataflow;
  logic [COLS-1:0]          out_propagate;
  logic [COLS-1:0]          out_valid;
  logic                     busy;
  logic                     done;

  modport slave (
    input  in_valid, in_last, in_a, in_b, in_d, in_dataflow, in_propagate,
    output in_ready, out_a, out_b, out_d, out_dataflow, out_propagate,
    output out_valid, busy, done
  );

  modport master (
    output in_valid, in_last, in_a, in_b, in_d, in_dataflow, in_propagate,
    input  in_ready, out_a, out_b, out_d, out_dataflow, out_propagate,
    input  out_valid, busy, done
  );
endinterface

// File: rtl/mesh_feeder.sv
// Skews incoming A/B/D beats into a diagonal wavefront for the mesh edges and
// tracks batch completion with a small IDLE/STREAM/DRAIN controller.
module mesh_feeder #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int BITWIDTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  mesh_feeder_if.slave  bus
);
  localparam int MAXD = (ROWS > COLS) ? ROWS : COLS;
  localparam int CNTW = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int CW   = 2*BITWIDTH + 3;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t          r_state, w_state_next;
  logic [CNTW-1:0] r_cnt, w_cnt_next;
  logic            w_in_ready;
  logic            w_accept;

  assign w_in_ready   = (r_state != DRAIN);
  assign w_accept     = bus.in_valid && w_in_ready;
  assign bus.in_ready = w_in_ready;
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = (r_state == DRAIN) && (r_cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // The counter loads when DRAIN is entered so done lands with the last lane.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.in_last) begin
            w_state_next = DRAIN;
            w_cnt_next   = CNTW'(MAXD - 1);
          end else begin
            w_state_next = STREAM;
          end
        end
      end
      STREAM: begin
        if (w_accept && bus.in_last) begin
          w_state_next = DRAIN;
          w_cnt_next   = CNTW'(MAXD - 1);
        end
      end
      DRAIN: begin
        if (r_cnt == '0) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [BITWIDTH-1:0] r_pipe [0:gi];

      always_ff @(posedge clock) begin
        if (reset) begin
          for (int s = 0; s <= gi; s++) r_pipe[s] <= '0;
        end else begin
          r_pipe[0] <= w_accept ? bus.in_a[gi*BITWIDTH +: BITWIDTH] : '0;
          for (int s = 1; s <= gi; s++) r_pipe[s] <= r_pipe[s-1];
        end
      end

      assign bus.out_a[gi*BITWIDTH +: BITWIDTH] = r_pipe[gi];
    end

    for (gi = 0; gi < COLS; gi++) begin : g_col
      // Packed as {valid, propagate, dataflow, d, b}; bubbles shift in zeros.
      logic [CW-1:0] r_pipe [0:gi];
      logic [CW-1:0] w_head;

      assign w_head = w_accept ?
                      {1'b1, bus.in_propagate, bus.in_dataflow,
                       bus.in_d[gi*BITWIDTH +: BITWIDTH],
                       bus.in_b[gi*BITWIDTH +: BITWIDTH]} : '0;

      always_ff @(posedge clock) begin
        if (reset) begin
          for (int s = 0; s <= gi; s++) r_pipe[s] <= '0;
        end else begin
          r_pipe[0] <= w_head;
          for (int s = 1; s <= gi; s++) r_pipe[s] <= r_pipe[s-1];
        end
      end

      assign bus.out_b[gi*BITWIDTH +: BITWIDTH] = r_pipe[gi][BITWIDTH-1:0];
      assign bus.out_d[gi*BITWIDTH +: BITWIDTH] = r_pipe[gi][2*BITWIDTH-1:BITWIDTH];
      assign bus.out_dataflow[gi]  = r_pipe[gi][2*BITWIDTH];
      assign bus.out_propagate[gi] = r_pipe[gi][2*BITWIDTH+1];
      assign bus.out_valid[gi]     = r_pipe[gi][2*BITWIDTH+2];
    end
  endgenerate
endmodule

// File: tb/tb_mesh_feeder.sv
// Scoreboard bench for mesh_feeder: stimulus queues per-lane expectations
// stamped with the cycle they must appear; a negedge monitor checks every lane.
module tb_mesh_feeder;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int BW   = 8;
  localparam int MAXD = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mesh_feeder_if #(.ROWS(ROWS), .COLS(COLS), .BITWIDTH(BW)) bus ();

  mesh_feeder #(.ROWS(ROWS), .COLS(COLS), .BITWIDTH(BW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int            stamp;
    logic [BW-1:0] v;
  } a_exp_t;

  typedef struct {
    int            stamp;
    logic [BW-1:0] b;
    logic [BW-1:0] d;
    logic          df;
    logic          pr;
  } c_exp_t;

  a_exp_t qa [ROWS][$];
  c_exp_t qc [COLS][$];
  int     qd [$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: stamp s is the cycle following rising edge number s.
  always @(negedge clock) begin
    logic [BW-1:0] av, bv, dv;
    c_exp_t        ce;
    if (mon_en) begin
      for (int i = 0; i < ROWS; i++) begin
        av = bus.out_a[i*BW +: BW];
        if (qa[i].size() > 0 && qa[i][0].stamp == cyc) begin
          chk($sformatf("out_a[%0d]", i), 32'(av), 32'(qa[i][0].v));
          void'(qa[i].pop_front());
        end else begin
          chk($sformatf("out_a[%0d] idle", i), 32'(av), 32'h0);
        end
      end
      for (int j = 0; j < COLS; j++) begin
        bv = bus.out_b[j*BW +: BW];
        dv = bus.out_d[j*BW +: BW];
        if (qc[j].size() > 0 && qc[j][0].stamp == cyc) begin
          ce = qc[j].pop_front();
          chk($sformatf("out_valid[%0d]", j), 32'(bus.out_valid[j]), 32'h1);
          chk($sformatf("out_b[%0d]", j), 32'(bv), 32'(ce.b));
          chk($sformatf("out_d[%0d]", j), 32'(dv), 32'(ce.d));
          chk($sformatf("ctl[%0d]", j), {30'h0, bus.out_propagate[j], bus.out_dataflow[j]},
              {30'h0, ce.pr, ce.df});
        end else begin
          chk($sformatf("out_valid[%0d] idle", j), 32'(bus.out_valid[j]), 32'h0);
          chk($sformatf("col[%0d] idle", j),
              {14'h0, bus.out_propagate[j], bus.out_dataflow[j], dv, bv}, 32'h0);
        end
      end
      if (qd.size() > 0 && qd[0] == cyc) begin
        chk("done", 32'(bus.done), 32'h1);
        void'(qd.pop_front());
      end else begin
        chk("done idle", 32'(bus.done), 32'h0);
      end
    end
  end

  task automatic drive_idle();
    bus.in_valid     = 1'b0;
    bus.in_last      = 1'b0;
    bus.in_a         = '0;
    bus.in_b         = '0;
    bus.in_d         = '0;
    bus.in_dataflow  = 1'b0;
    bus.in_propagate = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Presents a beat, waits (bounded) for acceptance and returns its edge number.
  task automatic send(input logic [ROWS*BW-1:0] a, input logic [COLS*BW-1:0] b,
                      input logic [COLS*BW-1:0] d, input logic df, input logic pr,
                      input logic last, output int e);
    int guard;
    bus.in_valid     = 1'b1;
    bus.in_last      = last;
    bus.in_a         = a;
    bus.in_b         = b;
    bus.in_d         = d;
    bus.in_dataflow  = df;
    bus.in_propagate = pr;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clock);
      #1;
      guard++;
    end
    if (!bus.in_ready) begin
      chk("accept timeout", 32'(bus.in_ready), 32'h1);
      e = -1;
    end else begin
      e = cyc + 1;
      for (int i = 0; i < ROWS; i++) qa[i].push_back('{e + i, a[i*BW +: BW]});
      for (int j = 0; j < COLS; j++)
        qc[j].push_back('{e + j, b[j*BW +: BW], d[j*BW +: BW], df, pr});
      if (last) qd.push_back(e + MAXD - 1);
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int e1, e2, e3;
    drive_idle();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    chk("reset in_ready", 32'(bus.in_ready), 32'h1);
    chk("reset busy", 32'(bus.busy), 32'h0);
    chk("reset done", 32'(bus.done), 32'h0);

    // Single last beat: a=(1,2,3,4), b=(5,6,7,8).
    send({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, '0, 1'b0, 1'b0, 1'b1, e1);
    drive_idle();
    chk("drain in_ready", 32'(bus.in_ready), 32'h0);
    chk("drain busy", 32'(bus.busy), 32'h1);
    wait_cycles(3);
    chk("drain end in_ready", 32'(bus.in_ready), 32'h0);
    wait_cycles(1);
    chk("idle in_ready", 32'(bus.in_ready), 32'h1);
    chk("idle busy", 32'(bus.busy), 32'h0);

    // Three back-to-back beats, lane0 = 10, 20, 30.
    send({8'd13, 8'd12, 8'd11, 8'd10}, {8'h44, 8'h33, 8'h22, 8'h11}, {8'h04, 8'h03, 8'h02, 8'h01},
         1'b1, 1'b0, 1'b0, e1);
    chk("stream busy", 32'(bus.busy), 32'h1);
    chk("stream in_ready", 32'(bus.in_ready), 32'h1);
    send({8'd23, 8'd22, 8'd21, 8'd20}, {8'h55, 8'h66, 8'h77, 8'h88}, '0, 1'b0, 1'b1, 1'b0, e2);
    send({8'd33, 8'd32, 8'd31, 8'd30}, {8'h99, 8'hAA, 8'hBB, 8'hCC}, {8'h7F, 8'h00, 8'h00, 8'h01},
         1'b1, 1'b1, 1'b1, e3);
    chk("back-to-back spacing", 32'(e3 - e1), 32'd2);
    drive_idle();
    wait_cycles(6);

    // Beat, bubble, last beat.
    send({8'd1, 8'd1, 8'd1, 8'd1}, {8'd2, 8'd2, 8'd2, 8'd2}, {8'd3, 8'd3, 8'd3, 8'd3},
         1'b0, 1'b1, 1'b0, e1);
    drive_idle();
    wait_cycles(1);
    chk("bubble keeps busy", 32'(bus.busy), 32'h1);
    send({8'd9, 8'd8, 8'd7, 8'd6}, {8'd5, 8'd4, 8'd3, 8'd2}, {8'd1, 8'd0, 8'd1, 8'd0},
         1'b1, 1'b0, 1'b1, e2);
    chk("bubble spacing", 32'(e2 - e1), 32'd2);
    drive_idle();
    wait_cycles(6);

    // Sign preservation: a lane3 = -128, d lane2 = -1.
    send({8'h80, 8'h00, 8'h00, 8'h00}, '0, {8'h00, 8'hFF, 8'h00, 8'h00}, 1'b1, 1'b1, 1'b1, e1);
    drive_idle();
    wait_cycles(5);

    // Reset in the cycle the third beat of a batch is presented.
    send({8'd4, 8'd3, 8'd2, 8'd1}, {8'd1, 8'd2, 8'd3, 8'd4}, '0, 1'b0, 1'b0, 1'b0, e1);
    send({8'd5, 8'd6, 8'd7, 8'd8}, {8'd8, 8'd7, 8'd6, 8'd5}, '0, 1'b0, 1'b0, 1'b0, e2);
    bus.in_a    = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    bus.in_b    = {8'h11, 8'h22, 8'h33, 8'h44};
    bus.in_last = 1'b1;
    bus.in_valid = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    #1;
    for (int i = 0; i < ROWS; i++) qa[i].delete();
    for (int j = 0; j < COLS; j++) qc[j].delete();
    qd.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive_idle();
    chk("post-reset in_ready", 32'(bus.in_ready), 32'h1);
    chk("post-reset busy", 32'(bus.busy), 32'h0);
    chk("post-reset done", 32'(bus.done), 32'h0);
    wait_cycles(6);
    chk("post-reset still idle", 32'(bus.busy), 32'h0);

    // in_valid held through DRAIN: next beat waits for the first IDLE cycle.
    send({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8}, '0, 1'b0, 1'b0, 1'b1, e1);
    send({8'hF0, 8'hE0, 8'hD0, 8'hC0}, {8'h0F, 8'h0E, 8'h0D, 8'h0C}, {8'h01, 8'h02, 8'h03, 8'h04},
         1'b1, 1'b0, 1'b1, e2);
    chk("drain hold spacing", 32'(e2 - e1), 32'd5);
    drive_idle();
    wait_cycles(6);

    for (int i = 0; i < ROWS; i++) chk($sformatf("a[%0d] leftovers", i), 32'(qa[i].size()), 32'h0);
    for (int j = 0; j < COLS; j++) chk($sformatf("col[%0d] leftovers", j), 32'(qc[j].size()), 32'h0);
    chk("done leftovers", 32'(qd.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
